aes_128: RTL and testbench
==========================

// Module: aes_128
// PURPOSE
// - Multicycle AES-128 encryption engine (FIPS-197, encrypt only).
// - Takes one 128-bit plaintext block and one 128-bit cipher key and produces the ciphertext.
// - Runs on a fixed, free-running 10-cycle schedule: one capture slot, then rounds, then result.
// - Round keys are expanded on the fly, one per cycle; no key storage beyond the current round key.
// PARAMETERS
// - none
// PORTS
// - clk      input   1    system clock, all state updates on rising edge
// - rst_n    input   1    asynchronous active-low reset
// - in_bus   input   128  plaintext; bits [127:120] = byte 0 (FIPS-197 column-major order)
// - key      input   128  cipher key, same byte order as in_bus
// - out_bus  output  128  ciphertext, same byte order; 0 whenever valid=0
// - ready    output  1    1 = in_bus/key are captured on the next rising edge
// - valid    output  1    1 = out_bus holds the ciphertext of the last captured block
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low.
// - Registers:
//   - cnt[3:0]: slot counter
//   - state[127:0]: AES state
//   - rk[127:0]: current round key
//   - done: sticky, 1 once a block has completed
// - Reset (rst_n=0), applied immediately:
//   - cnt=9, state=0, rk=0, done=0
//   - ready=0, valid=0, out_bus=0
// - Schedule: cnt runs 9 -> 0 -> 1 -> ... -> 9 -> 0, advancing every edge and never stalling.
// - First edge after reset release: cnt 9 -> 0, no capture. The second edge is the first capture edge.
// - ready = (cnt==0). The handshake is advisory: the capture happens at cnt==0 whether or not the source is ready.
// - Inputs are sampled only on the cnt==0 edge. They are ignored (may toggle freely) for the other 9 edges.
// - Capture edge (cnt==0):
//   - rk <= expand(key, rcon=01)
//   - state <= round(in_bus^key, expand(key,01))
// - Edges with cnt=1..8: performs rounds 2..9.
//   - rk <= expand(rk, rcon[cnt+1])
//   - state <= round(state, expand(rk, rcon[cnt+1]))
// - Edge with cnt=8 also sets done=1.
// - Edge with cnt=9: state and rk hold; cnt -> 0.
// - round(s,k) = MixColumns(ShiftRows(SubBytes(s))) ^ k.
// - Final round is combinational from the registers:
//   - out_bus = ShiftRows(SubBytes(state)) ^ expand(rk, 36)
//   - out_bus is gated to 0 when valid=0.
// - valid = done && (cnt==9). It is high for exactly 1 cycle per block, starting after the 9th edge counted from the capture edge inclusive.
// - Throughput: one block per 10 cycles; back-to-back captures are 10 edges apart.
// - expand(w, rc), using 32-bit words w0..w3 MSB-first:
//   - t = SubWord(RotWord(w3)) ^ {rc,24'h0}
//   - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
// - rcon sequence, rounds 1..10: 01 02 04 08 10 20 40 80 1b 36.
// - S-box: combinational (case ROM or composite-field); 16 for data plus 4 for the key schedule.
// - Reset mid-operation: the block in flight is discarded; restart as from power-up (valid=0 until a new block completes).
// - Reset asserted during a valid cycle: valid and out_bus drop to 0 immediately.
// TESTING
// - Reset 2 cycles, release; check ready=0 in first cycle, ready=1 after first edge, valid=0, out_bus=0 throughout.
// - FIPS-197 App.B: in_bus=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> out_bus=3925841d02dc09fbdc118597196a0b32, valid=1 after 9th edge.
// - FIPS-197 App.C.1: in_bus=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
// - All-zero: in_bus=0, key=0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Randomize inputs on all non-capture edges; the result must be unchanged.
// - Back-to-back: the three vectors above applied every 10 cycles. Each result appears with valid=1 for 1 cycle, 10 cycles apart, in order.
// - Assert rst_n=0 at cnt=5 mid-block: outputs go to 0 at once; after release no valid pulse until a fresh capture completes.

Source files
------------

// File: rtl/aes_128.sv
// ---------------------------------------------------------------------------
// aes_128 -- multicycle AES-128 encryption engine (encrypt only).
//
// One block is accepted every 10 cycles on a free-running slot counter:
// slot 0 captures the inputs and performs round 1. Slots 1..8 perform
// rounds 2..9. Slot 9 presents the final round combinationally and holds.
// Round keys are expanded on the fly; only the current round key is kept.
//
// Ports:
//   clk      in   1    system clock, rising edge
//   rst_n    in   1    asynchronous active-low reset
//   in_bus   in   128  plaintext, bits [127:120] = byte 0 (column-major)
//   key      in   128  cipher key, same byte order
//   out_bus  out  128  ciphertext, forced to 0 while valid = 0
//   ready    out  1    inputs are captured on the next rising edge
//   valid    out  1    out_bus holds the ciphertext of the last captured block
// ---------------------------------------------------------------------------
module aes_128 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in_bus,
    input  logic [127:0] key,
    output logic [127:0] out_bus,
    output logic         ready,
    output logic         valid
);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows: row r of column c takes column (c+r)%4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = sbox(s[127 - 8*(row + 4*((c + row) % 4)) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // One key-schedule step: next round key from the previous one.
    function automatic logic [127:0] expand(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h0};
        w0 = w[127:96] ^ t;
        w1 = w[95:64]  ^ w0;
        w2 = w[63:32]  ^ w1;
        w3 = w[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic         done_q, done_d;

    logic         capture;
    logic [127:0] key_src, state_src, rk_next, sr;
    logic [7:0]   rc;

    // The same 16 data S-boxes and 4 key S-boxes serve every slot: in slot 9
    // they compute the final round (rcon 36) from the held registers.
    // NOTE: every signal gets a value at the top of the block so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        capture   = (cnt_q == 4'd0);
        key_src   = capture ? key : rk_q;
        state_src = capture ? (in_bus ^ key) : state_q;
        rc        = (cnt_q == 4'd9) ? 8'h36 : rcon(cnt_q + 4'd1);
        rk_next   = expand(key_src, rc);
        sr        = sub_shift(state_src);

        cnt_d   = (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
        state_d = state_q;
        rk_d    = rk_q;
        done_d  = done_q;
        if (cnt_q != 4'd9) begin
            state_d = mix_columns(sr) ^ rk_next;
            rk_d    = rk_next;
        end
        if (cnt_q == 4'd8) begin
            done_d = 1'b1;
        end

        ready   = capture;
        valid   = done_q && (cnt_q == 4'd9);
        out_bus = valid ? (sr ^ rk_next) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd9;
            state_q <= '0;
            rk_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_128.sv
// ---------------------------------------------------------------------------
// tb_aes_128 -- directed known-answer bench for aes_128.
// Inputs are driven on the falling edge and outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_aes_128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_bus;
    logic [127:0] key;
    logic [127:0] out_bus;
    logic         ready;
    logic         valid;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_128 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_bus  (in_bus),
        .key     (key),
        .out_bus (out_bus),
        .ready   (ready),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Bounded wait (on falling edges) for the capture slot.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called on a falling edge with ready=1. Drives one block, observes the
    // result after the 9th edge, and returns one edge later (next capture slot).
    task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input bit scramble,
                             output logic [127:0] ct, output bit early, output logic vld,
                             output bit late, output time t_valid);
        in_bus = pt;
        key    = k;
        early  = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid !== 1'b0) early = 1'b1;
            if (scramble) begin
                in_bus = rand128();
                key    = rand128();
            end
        end
        @(posedge clk);
        @(negedge clk);
        vld     = valid;
        ct      = out_bus;
        t_valid = $time;
        if (scramble) begin
            in_bus = rand128();
            key    = rand128();
        end
        @(posedge clk);
        @(negedge clk);
        late = (valid !== 1'b0) || (out_bus !== '0);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        in_bus = '0;
        key    = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if (ready !== 1'b0 || valid !== 1'b0 || out_bus !== '0)
            $display("FAIL reset_hold: ready=%b valid=%b out_bus=%h, expected 0 0 0", ready, valid, out_bus);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++;
        if (ready !== 1'b0)
            $display("FAIL ready_before_first_edge: ready=%b, expected 0", ready);
        else n_pass++;
        n_total++;
        if (valid !== 1'b0 || out_bus !== '0)
            $display("FAIL outputs_after_release: valid=%b out_bus=%h, expected 0 0", valid, out_bus);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (ready !== 1'b1)
            $display("FAIL ready_after_first_edge: ready=%b, expected 1", ready);
        else n_pass++;
        n_total++;
        if (valid !== 1'b0 || out_bus !== '0)
            $display("FAIL outputs_after_first_edge: valid=%b out_bus=%h, expected 0 0", valid, out_bus);
        else n_pass++;
    endtask

    task automatic test_known_answers();
        logic [127:0] pts [3];
        logic [127:0] keys[3];
        logic [127:0] cts [3];
        logic [127:0] ct;
        logic         vld;
        bit           ok, early, late;
        time          tv;
        pts[0] = PT_B;  keys[0] = KEY_B; cts[0] = CT_B;
        pts[1] = PT_C;  keys[1] = KEY_C; cts[1] = CT_C;
        pts[2] = '0;    keys[2] = '0;    cts[2] = CT_Z;
        for (int i = 0; i < 3; i++) begin
            wait_ready(ok);
            n_total++;
            if (!ok) $display("FAIL kat%0d_ready: ready never rose within 20 cycles, expected 1", i);
            else n_pass++;
            run_block(pts[i], keys[i], 1'b0, ct, early, vld, late, tv);
            n_total++;
            if (early) $display("FAIL kat%0d_early_valid: valid rose before 9th edge, expected 0", i);
            else n_pass++;
            n_total++;
            if (vld !== 1'b1) $display("FAIL kat%0d_valid: valid=%b, expected 1", i, vld);
            else n_pass++;
            n_total++;
            if (ct !== cts[i]) $display("FAIL kat%0d_out_bus: got %h, expected %h", i, ct, cts[i]);
            else n_pass++;
            n_total++;
            if (late) $display("FAIL kat%0d_valid_width: valid/out_bus nonzero after pulse, expected 0", i);
            else n_pass++;
        end
    endtask

    task automatic test_scramble();
        logic [127:0] ct;
        logic         vld;
        bit           ok, early, late;
        time          tv;
        wait_ready(ok);
        n_total++;
        if (!ok) $display("FAIL scramble_ready: ready never rose, expected 1");
        else n_pass++;
        run_block('0, '0, 1'b1, ct, early, vld, late, tv);
        n_total++;
        if (vld !== 1'b1 || early) $display("FAIL scramble_valid: valid=%b early=%b, expected 1 0", vld, early);
        else n_pass++;
        n_total++;
        if (ct !== CT_Z) $display("FAIL scramble_out_bus: got %h, expected %h", ct, CT_Z);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct [3];
        logic         vld[3];
        time          tv [3];
        bit           early[3];
        bit           late[3];
        bit           ok;
        wait_ready(ok);
        n_total++;
        if (!ok) $display("FAIL b2b_ready: ready never rose, expected 1");
        else n_pass++;
        run_block(PT_B, KEY_B, 1'b0, ct[0], early[0], vld[0], late[0], tv[0]);
        run_block(PT_C, KEY_C, 1'b0, ct[1], early[1], vld[1], late[1], tv[1]);
        run_block('0,   '0,    1'b0, ct[2], early[2], vld[2], late[2], tv[2]);
        n_total++;
        if (vld[0] !== 1'b1 || ct[0] !== CT_B) $display("FAIL b2b_first: valid=%b out_bus=%h, expected 1 %h", vld[0], ct[0], CT_B);
        else n_pass++;
        n_total++;
        if (vld[1] !== 1'b1 || ct[1] !== CT_C) $display("FAIL b2b_second: valid=%b out_bus=%h, expected 1 %h", vld[1], ct[1], CT_C);
        else n_pass++;
        n_total++;
        if (vld[2] !== 1'b1 || ct[2] !== CT_Z) $display("FAIL b2b_third: valid=%b out_bus=%h, expected 1 %h", vld[2], ct[2], CT_Z);
        else n_pass++;
        n_total++;
        if (tv[1] - tv[0] != 100 || tv[2] - tv[1] != 100)
            $display("FAIL b2b_spacing: gaps %0t %0t, expected 100 100", tv[1] - tv[0], tv[2] - tv[1]);
        else n_pass++;
        n_total++;
        if (early[1] || early[2] || late[2]) $display("FAIL b2b_pulse_width: extra valid seen, expected single pulses");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, early;
        // Reset during the valid cycle.
        wait_ready(ok);
        n_total++;
        if (!ok) $display("FAIL rst_ready: ready never rose, expected 1");
        else n_pass++;
        in_bus = PT_B;
        key    = KEY_B;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_total++;
        if (valid !== 1'b1 || out_bus !== CT_B)
            $display("FAIL pre_reset_valid: valid=%b out_bus=%h, expected 1 %h", valid, out_bus, CT_B);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (valid !== 1'b0 || out_bus !== '0 || ready !== 1'b0)
            $display("FAIL reset_in_valid_cycle: valid=%b ready=%b out_bus=%h, expected 0 0 0", valid, ready, out_bus);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if (valid !== 1'b0)
            $display("FAIL valid_after_release: valid=%b, expected 0", valid);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        // Reset mid-block at cnt=5.
        in_bus = PT_B;
        key    = KEY_B;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_total++;
        if (valid !== 1'b0 || out_bus !== '0 || ready !== 1'b0)
            $display("FAIL reset_mid_block: valid=%b ready=%b out_bus=%h, expected 0 0 0", valid, ready, out_bus);
        else n_pass++;
        in_bus = PT_C;
        key    = KEY_C;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        early = (valid !== 1'b0);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid !== 1'b0) early = 1'b1;
        end
        n_total++;
        if (early) $display("FAIL no_valid_before_fresh_block: valid seen, expected 0");
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (valid !== 1'b1 || out_bus !== CT_C)
            $display("FAIL fresh_block_after_reset: valid=%b out_bus=%h, expected 1 %h", valid, out_bus, CT_C);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_known_answers();
        test_scramble();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
